// File: rtl/td4_pkg.sv
// td4_pkg -- shared definitions for the TD4 4-bit CPU, its ROM images and
// the assembler tests: data width, opcode constants and source-select codes.
package td4_pkg;

  localparam int DATA_W = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [3:0]        opcode_t;

  // Opcode map (rom_dout[7:4])
  localparam opcode_t OP_ADD_A   = 4'b0000;
  localparam opcode_t OP_MOV_AB  = 4'b0001;
  localparam opcode_t OP_IN_A    = 4'b0010;
  localparam opcode_t OP_MOV_AI  = 4'b0011;
  localparam opcode_t OP_MOV_BA  = 4'b0100;
  localparam opcode_t OP_ADD_B   = 4'b0101;
  localparam opcode_t OP_IN_B    = 4'b0110;
  localparam opcode_t OP_MOV_BI  = 4'b0111;
  localparam opcode_t OP_OUT_B   = 4'b1001;
  localparam opcode_t OP_OUT_I   = 4'b1011;
  localparam opcode_t OP_JNC     = 4'b1110;
  localparam opcode_t OP_JMP     = 4'b1111;

  // ALU source operand select
  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_t;

  // Split an instruction byte into opcode and immediate
  function automatic opcode_t instr_op(input logic [7:0] instr);
    return instr[7:4];
  endfunction

  function automatic data_t instr_imm(input logic [7:0] instr);
    return instr[3:0];
  endfunction

endpackage

// File: rtl/td4_if.sv
// td4_if -- instruction ROM bus between the CPU and its program store.
//   rom_adr  : 4-bit instruction address driven by the CPU (equal to PC)
//   rom_dout : 8-bit instruction returned combinationally by the ROM
// master = CPU side, slave = ROM side.
interface td4_if;
  import td4_pkg::*;

  logic [3:0] rom_adr;
  logic [7:0] rom_dout;

  modport master (output rom_adr, input rom_dout);
  modport slave  (input rom_adr, output rom_dout);

endinterface

// File: rtl/td4_decode.sv
// td4_decode -- purely combinational instruction decoder.
//   op        : instruction opcode
//   carry     : current carry flag (before this instruction's update)
//   src_sel   : ALU source operand select
//   we_a/we_b : write enables for registers A and B
//   we_out    : write enable for the output latch
//   pc_load   : load PC with the ALU result instead of PC+1
//   carry_clr : force carry to 0 (undefined opcodes)
module td4_decode
  import td4_pkg::*;
(
  input  opcode_t  op,
  input  logic     carry,
  output src_sel_t src_sel,
  output logic     we_a,
  output logic     we_b,
  output logic     we_out,
  output logic     pc_load,
  output logic     carry_clr
);

  // Opcode to control-signal decode; undefined opcodes fall to a carry-clearing NOP
  always_comb begin
    src_sel   = SRC_ZERO;
    we_a      = 1'b0;
    we_b      = 1'b0;
    we_out    = 1'b0;
    pc_load   = 1'b0;
    carry_clr = 1'b0;
    case (op)
      OP_ADD_A:  begin src_sel = SRC_A;    we_a   = 1'b1; end
      OP_MOV_AB: begin src_sel = SRC_B;    we_a   = 1'b1; end
      OP_IN_A:   begin src_sel = SRC_IN;   we_a   = 1'b1; end
      OP_MOV_AI: begin src_sel = SRC_ZERO; we_a   = 1'b1; end
      OP_MOV_BA: begin src_sel = SRC_A;    we_b   = 1'b1; end
      OP_ADD_B:  begin src_sel = SRC_B;    we_b   = 1'b1; end
      OP_IN_B:   begin src_sel = SRC_IN;   we_b   = 1'b1; end
      OP_MOV_BI: begin src_sel = SRC_ZERO; we_b   = 1'b1; end
      OP_OUT_B:  begin src_sel = SRC_B;    we_out = 1'b1; end
      OP_OUT_I:  begin src_sel = SRC_ZERO; we_out = 1'b1; end
      // JNC tests the carry as it was before this instruction executes
      OP_JNC: begin
        src_sel = SRC_ZERO;
        if (carry == 1'b0) begin
          pc_load = 1'b1;
        end else begin
          pc_load = 1'b0;
        end
      end
      OP_JMP:    begin src_sel = SRC_ZERO; pc_load = 1'b1; end
      default:   begin src_sel = SRC_ZERO; carry_clr = 1'b1; end
    endcase
  end

endmodule

// File: rtl/td4_cpu.sv
// td4_cpu -- single-cycle TD4 4-bit CPU. Every enabled clock edge fetches,
// decodes and executes one instruction from the combinational ROM.
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset, priority over ce
//   ce       : step enable
//   rom_bus  : instruction ROM bus (rom_adr = PC, rom_dout = instruction)
//   in_port  : 4-bit input sampled by IN instructions at the committing edge
//   out_port : 4-bit registered output latch
//   carry    : carry flag (debug)
//   reg_a/b  : registers A and B (debug)
module td4_cpu
  import td4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  td4_if.master        rom_bus,
  input  data_t        in_port,
  output data_t        out_port,
  output logic         carry,
  output data_t        reg_a,
  output data_t        reg_b
);

  logic [3:0] pc_r;
  data_t      a_r;
  data_t      b_r;
  data_t      out_r;
  logic       carry_r;

  opcode_t    op_s;
  data_t      imm_s;
  src_sel_t   src_sel_s;
  logic       we_a_s;
  logic       we_b_s;
  logic       we_out_s;
  logic       pc_load_s;
  logic       carry_clr_s;
  data_t      src_s;
  logic [4:0] sum_s;
  logic [3:0] pc_next_s;

  assign op_s  = instr_op(rom_bus.rom_dout);
  assign imm_s = instr_imm(rom_bus.rom_dout);

  td4_decode u_decode (
    .op        (op_s),
    .carry     (carry_r),
    .src_sel   (src_sel_s),
    .we_a      (we_a_s),
    .we_b      (we_b_s),
    .we_out    (we_out_s),
    .pc_load   (pc_load_s),
    .carry_clr (carry_clr_s)
  );

  // ALU source operand mux
  always_comb begin
    src_s = 4'd0;
    case (src_sel_s)
      SRC_A:    src_s = a_r;
      SRC_B:    src_s = b_r;
      SRC_IN:   src_s = in_port;
      SRC_ZERO: src_s = 4'd0;
      default:  src_s = 4'd0;
    endcase
  end

  // 5-bit sum: bit 4 is the carry out, bits 3:0 the result
  assign sum_s = {1'b0, src_s} + {1'b0, imm_s};

  // Next PC: jump target from the ALU, otherwise increment (wraps 15 -> 0)
  always_comb begin
    if (pc_load_s) begin
      pc_next_s = sum_s[3:0];
    end else begin
      pc_next_s = pc_r + 4'd1;
    end
  end

  // Architectural state: commit on enabled edges, reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= 4'd0;
      a_r     <= 4'd0;
      b_r     <= 4'd0;
      out_r   <= 4'd0;
      carry_r <= 1'b0;
    end else if (ce) begin
      pc_r    <= pc_next_s;
      if (we_a_s)   a_r   <= sum_s[3:0];
      if (we_b_s)   b_r   <= sum_s[3:0];
      if (we_out_s) out_r <= sum_s[3:0];
      carry_r <= carry_clr_s ? 1'b0 : sum_s[4];
    end
  end

  assign rom_bus.rom_adr = pc_r;
  assign out_port        = out_r;
  assign carry           = carry_r;
  assign reg_a           = a_r;
  assign reg_b           = b_r;

endmodule

// File: tb/tb_td4_cpu.sv
// tb_td4_cpu -- directed self-checking bench for td4_cpu with a small
// combinational ROM; expected values are hand-computed from the ISA.
module tb_td4_cpu;
  import td4_pkg::*;

  logic  clk;
  logic  rst;
  logic  ce;
  data_t in_port;
  data_t out_port;
  logic  carry;
  data_t reg_a;
  data_t reg_b;

  logic [7:0] rom_mem [16];

  int n_cmp;
  int n_bad;

  td4_if rom_bus ();

  assign rom_bus.rom_dout = rom_mem[rom_bus.rom_adr];

  td4_cpu dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .rom_bus  (rom_bus),
    .in_port  (in_port),
    .out_port (out_port),
    .carry    (carry),
    .reg_a    (reg_a),
    .reg_b    (reg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;
  endtask

  // Reset with ce held high so reset priority is exercised every time
  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    ce      = 1'b0;
    in_port = 4'h0;
    rom_clear();

    // Reset and PC stepping over an all-zero ROM
    do_reset();
    chk("rst_pc",  {4'h0, rom_bus.rom_adr}, 8'h00);
    chk("rst_a",   {4'h0, reg_a},   8'h00);
    chk("rst_b",   {4'h0, reg_b},   8'h00);
    chk("rst_out", {4'h0, out_port}, 8'h00);
    chk("rst_c",   {7'h0, carry},   8'h00);
    ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("step_pc", {4'h0, rom_bus.rom_adr}, 8'(i));
      step();
    end
    chk("step_pc5", {4'h0, rom_bus.rom_adr}, 8'h05);
    do_reset();
    chk("rerst_pc", {4'h0, rom_bus.rom_adr}, 8'h00);
    chk("rerst_a",  {4'h0, reg_a}, 8'h00);
    chk("rerst_c",  {7'h0, carry}, 8'h00);

    // Carry generation and JNC fall-through
    rom_clear();
    rom_mem[0] = 8'h3F;
    rom_mem[1] = 8'h01;
    rom_mem[2] = 8'hE5;
    do_reset();
    ce = 1'b1;
    step();
    chk("mov_a",   {4'h0, reg_a}, 8'h0F);
    chk("mov_c",   {7'h0, carry}, 8'h00);
    step();
    chk("add_a",   {4'h0, reg_a}, 8'h00);
    chk("add_c",   {7'h0, carry}, 8'h01);
    step();
    chk("jnc_pc",  {4'h0, rom_bus.rom_adr}, 8'h03);
    chk("jnc_c",   {7'h0, carry}, 8'h00);

    // JNC counting loop
    rom_clear();
    rom_mem[0] = 8'h01;
    rom_mem[1] = 8'hE0;
    do_reset();
    ce = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("loop_a", {4'h0, reg_a}, 8'(k % 16));
      chk("loop_c", {7'h0, carry}, (k == 16) ? 8'h01 : 8'h00);
      step();
      chk("loop_pc", {4'h0, rom_bus.rom_adr}, (k == 16) ? 8'h02 : 8'h00);
    end

    // IN B then OUT B
    rom_clear();
    rom_mem[0] = 8'h60;
    rom_mem[1] = 8'h90;
    in_port = 4'hA;
    do_reset();
    ce = 1'b1;
    step();
    chk("in_b", {4'h0, reg_b}, 8'h0A);
    in_port = 4'h3;
    step();
    chk("out_b", {4'h0, out_port}, 8'h0A);

    // Enable gating and undefined-opcode NOP
    rom_clear();
    rom_mem[0] = 8'h35;
    rom_mem[1] = 8'h7C;
    rom_mem[2] = 8'hB7;
    rom_mem[3] = 8'h80;
    rom_mem[4] = 8'h5F;
    rom_mem[5] = 8'h80;
    do_reset();
    ce = 1'b1;
    step();
    step();
    step();
    chk("outi", {4'h0, out_port}, 8'h07);
    ce = 1'b0;
    step();
    step();
    chk("hold_out", {4'h0, out_port}, 8'h07);
    chk("hold_pc",  {4'h0, rom_bus.rom_adr}, 8'h03);
    chk("hold_a",   {4'h0, reg_a}, 8'h05);
    chk("hold_b",   {4'h0, reg_b}, 8'h0C);
    ce = 1'b1;
    step();
    chk("nop_pc",  {4'h0, rom_bus.rom_adr}, 8'h04);
    chk("nop_a",   {4'h0, reg_a}, 8'h05);
    chk("nop_b",   {4'h0, reg_b}, 8'h0C);
    chk("nop_out", {4'h0, out_port}, 8'h07);
    step();
    chk("addb_b", {4'h0, reg_b}, 8'h0B);
    chk("addb_c", {7'h0, carry}, 8'h01);
    step();
    chk("nop2_c",  {7'h0, carry}, 8'h00);
    chk("nop2_b",  {4'h0, reg_b}, 8'h0B);
    chk("nop2_pc", {4'h0, rom_bus.rom_adr}, 8'h06);

    // JMP to 15, then increment wraps to 0
    rom_clear();
    rom_mem[0]  = 8'hFF;
    rom_mem[15] = 8'h00;
    do_reset();
    ce = 1'b1;
    step();
    chk("jmp_pc",  {4'h0, rom_bus.rom_adr}, 8'h0F);
    step();
    chk("wrap_pc", {4'h0, rom_bus.rom_adr}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/td4_cpu.md
TD4_CPU -- requirements
Module: td4_cpu

Interface
REQ-001 The block SHALL have ports clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-003 The block SHALL have port ce, input, 1, step enable; state SHALL update only on edges where ce=1 or rst=1.
REQ-004 The block SHALL have port rom_adr, output, 4, instruction address, always equal to PC.
REQ-005 The block SHALL have port rom_dout, input, 8, instruction from ROM, combinational in rom_adr; [7:4]=opcode, [3:0]=imm.
REQ-006 The block SHALL have port in_port, input, 4, external input sampled by IN instructions.
REQ-007 The block SHALL have port out_port, output, 4, registered output latch.
REQ-008 The block SHALL have port carry, output, 1, current carry flag, for debug.
REQ-009 The block SHALL have port reg_a and reg_b, output, 4 each, current A and B, for debug.

Function
REQ-010 Each instruction SHALL complete in one enabled cycle: fetch, decode and execute combinationally from rom_dout; all results commit at that edge.
REQ-011 ALU SHALL compute {co,res} = src + imm as a 5-bit sum, with src=A (opcode 0000), B (0001, 0101), in_port (0010, 0110), or 0 (0011, 0111, 1011, 1111, 1110).
REQ-012 Writes SHALL be: 0000 ADD A,imm->A; 0001 MOV A,B->A; 0010 IN A->A; 0011 MOV A,imm->A; 0100 MOV B,A->B (src=A); 0101 ADD B,imm->B; 0110 IN B->B; 0111 MOV B,imm->B; 1001 OUT B->out_port (src=B); 1011 OUT imm->out_port.
REQ-013 0100 and 1001 SHALL also add imm to src, so that imm=0 gives a pure move.
REQ-014 1111 JMP SHALL load PC with res; 1110 JNC SHALL load PC with res if carry=0, else PC+1.
REQ-015 All other instructions SHALL set PC to PC+1 modulo 16, so that 15 wraps to 0.
REQ-016 Carry SHALL be loaded with co on every enabled cycle of a defined opcode, including MOV, IN, OUT, JMP and JNC; JNC tests the value before the update.
REQ-017 Undefined opcodes (1000, 1010, 1100, 1101) SHALL be NOPs: no register or out_port write, PC+1, carry cleared.
REQ-018 When ce=0, all registers SHALL hold, and rom_adr SHALL remain stable.
REQ-019 in_port SHALL be sampled only at the committing edge; no synchronizer inside the block.

Reset
REQ-020 When rst=1 at an edge, the block SHALL set PC=0, A=0, B=0, out_port=0 and carry=0, regardless of ce and of any instruction in progress.
REQ-021 rst SHALL take priority over ce and over any executing instruction; the first instruction after reset SHALL execute from address 0.

Structure
REQ-022 Opcode constants, src-select encodings and the 4-bit data width SHALL live in a shared package td4_pkg, used also by the ROM and assembler tests.
REQ-023 One sub-module td4_decode SHALL be used: opcode plus carry in, giving src_sel, dest write-enables (A, B, OUT), pc_load and carry_clr out, purely combinational.
REQ-024 PC, A, B, out_port and carry SHALL be the only state elements.

Verification
REQ-025 The bench SHALL check reset: ROM all 0x00 with ce=1 for 5 cycles; PC SHALL step 0,1,2,3,4, then rst gives PC=0, A=0, carry=0.
REQ-026 The bench SHALL check carry: program 0x3F (MOV A,15), then 0x01 (ADD A,1); expect A=0 and carry=1, then 0xE5 (JNC 5) falls through to PC=3.
REQ-027 The bench SHALL check the JNC loop: program 0x01 (ADD A,1), then 0xE0 (JNC 0); A SHALL count 1..15 and 0 with carry=1, then PC SHALL advance to 2.
REQ-028 The bench SHALL check I/O: in_port=0xA; program 0x60 (IN B), then 0x90 (OUT B); out_port SHALL equal 0xA after the second enabled edge.
REQ-029 The bench SHALL check the enable and NOP path: ce toggled 1,0,0,1 over 0xB7 (OUT 7), then 0x80 (undefined); out_port=7 SHALL hold during ce=0, and the undefined opcode SHALL leave A, B and out_port unchanged with PC+1.
REQ-030 The bench SHALL check JMP and wrap: program 0xFF at address 0 gives PC=15; 0x00 at address 15 gives PC=0.
